// File: rtl/operand_stage.sv
// Register-read / operand stage: holds one instruction, resolves operands via bypass, resolves branches.
// Latency: one cycle (operands, branch result and redirect are combinational from the held register).
// Backpressure: holds fields stable while out_ready_i=0 or a load-use hazard is pending; in_ready_o drops.
module operand_stage #(
    parameter int XLEN     = 32,
    parameter int NUM_FWD  = 2,
    parameter int ALU_OP_W = 6,
    parameter int CTRL_W   = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [XLEN-1:0]         in_pc_i,
    input  logic [XLEN-1:0]         in_imm_i,
    input  logic [4:0]              in_rs1_i,
    input  logic [4:0]              in_rs2_i,
    input  logic [4:0]              in_rd_i,
    input  logic [ALU_OP_W-1:0]     in_alu_op_i,
    input  logic [4:0]              in_sel_i,
    input  logic [1:0]              in_jmp_opt_i,
    input  logic [CTRL_W-1:0]       in_ctrl_i,
    output logic [4:0]              rf_rs1_o,
    output logic [4:0]              rf_rs2_o,
    input  logic [XLEN-1:0]         rf_rs1_data_i,
    input  logic [XLEN-1:0]         rf_rs2_data_i,
    input  logic [NUM_FWD-1:0]      fwd_valid_i,
    input  logic [NUM_FWD-1:0]      fwd_pend_i,
    input  logic [NUM_FWD*5-1:0]    fwd_rd_i,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [XLEN-1:0]         out_src1_o,
    output logic [XLEN-1:0]         out_src2_o,
    output logic [XLEN-1:0]         out_rs2_data_o,
    output logic [4:0]              out_rd_o,
    output logic [ALU_OP_W-1:0]     out_alu_op_o,
    output logic [CTRL_W-1:0]       out_ctrl_o,
    output logic [XLEN-1:0]         out_pc_o,
    output logic                    out_jmp_o,
    output logic                    redirect_o,
    output logic [XLEN-1:0]         redirect_pc_o
);

    // sel layout: {use_rs1, use_rs2, src1_is_pc, src2_is_imm, jalr}
    typedef struct packed {
        logic [XLEN-1:0]     pc;
        logic [XLEN-1:0]     imm;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [ALU_OP_W-1:0] alu_op;
        logic                use_rs1;
        logic                use_rs2;
        logic                src1_is_pc;
        logic                src2_is_imm;
        logic                jalr;
        logic [1:0]          jmp_opt;
        logic [CTRL_W-1:0]   ctrl;
    } hdr_t;

    hdr_t            held_q;
    hdr_t            in_hdr;
    logic            valid_q;
    logic [XLEN-1:0] rs1v, rs2v;
    logic            haz1, haz2, hazard;
    logic            cmp;
    logic            fire_out;
    logic [XLEN-1:0] tgt_sum;

    assign in_hdr = '{pc: in_pc_i, imm: in_imm_i, rs1: in_rs1_i, rs2: in_rs2_i, rd: in_rd_i,
                      alu_op: in_alu_op_i, use_rs1: in_sel_i[4], use_rs2: in_sel_i[3],
                      src1_is_pc: in_sel_i[2], src2_is_imm: in_sel_i[1], jalr: in_sel_i[0],
                      jmp_opt: in_jmp_opt_i, ctrl: in_ctrl_i};

    // Operand bypass: scan oldest to youngest so the lowest matching channel wins; x0 reads as zero.
    always_comb begin
        rs1v = '0;
        rs2v = '0;
        if (held_q.rs1 != 5'd0) begin
            rs1v = rf_rs1_data_i;
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (fwd_valid_i[k] && (fwd_rd_i[5*k +: 5] == held_q.rs1))
                    rs1v = fwd_data_i[XLEN*k +: XLEN];
            end
        end
        if (held_q.rs2 != 5'd0) begin
            rs2v = rf_rs2_data_i;
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (fwd_valid_i[k] && (fwd_rd_i[5*k +: 5] == held_q.rs2))
                    rs2v = fwd_data_i[XLEN*k +: XLEN];
            end
        end
    end

    // Load-use detection: any pending channel targeting a used, non-zero source stalls the stage.
    always_comb begin
        haz1 = 1'b0;
        haz2 = 1'b0;
        for (int k = 0; k < NUM_FWD; k++) begin
            if (fwd_pend_i[k] && (fwd_rd_i[5*k +: 5] == held_q.rs1) && (held_q.rs1 != 5'd0) && held_q.use_rs1)
                haz1 = 1'b1;
            if (fwd_pend_i[k] && (fwd_rd_i[5*k +: 5] == held_q.rs2) && (held_q.rs2 != 5'd0) && held_q.use_rs2)
                haz2 = 1'b1;
        end
    end

    assign hazard = valid_q & (haz1 | haz2);

    // Branch comparator selected by alu_op[2:0]; unused encodings never take.
    always_comb begin
        cmp = 1'b0;
        case (held_q.alu_op[2:0])
            3'b000:  cmp = (rs1v == rs2v);
            3'b001:  cmp = (rs1v != rs2v);
            3'b100:  cmp = ($signed(rs1v) <  $signed(rs2v));
            3'b101:  cmp = ($signed(rs1v) >= $signed(rs2v));
            3'b110:  cmp = (rs1v <  rs2v);
            3'b111:  cmp = (rs1v >= rs2v);
            default: cmp = 1'b0;
        endcase
    end

    assign out_valid_o    = valid_q & ~hazard & ~flush_i;
    assign fire_out       = out_valid_o & out_ready_i;
    assign in_ready_o     = ~valid_q | fire_out | flush_i;

    assign rf_rs1_o       = held_q.rs1;
    assign rf_rs2_o       = held_q.rs2;
    assign out_src1_o     = held_q.src1_is_pc  ? held_q.pc  : rs1v;
    assign out_src2_o     = held_q.src2_is_imm ? held_q.imm : rs2v;
    assign out_rs2_data_o = rs2v;
    assign out_rd_o       = held_q.rd;
    assign out_alu_op_o   = held_q.alu_op;
    assign out_ctrl_o     = held_q.ctrl;
    assign out_pc_o       = held_q.pc;

    assign out_jmp_o      = (cmp & held_q.jmp_opt[1]) | held_q.jmp_opt[0];
    // Redirect only on the handshake cycle, so it fires once per instruction.
    assign redirect_o     = fire_out & out_jmp_o;
    assign tgt_sum        = (held_q.jalr ? rs1v : held_q.pc) + held_q.imm;
    assign redirect_pc_o  = {tgt_sum[XLEN-1:1], tgt_sum[0] & ~held_q.jalr};

    // Pipeline register: flush beats accept, accept beats drain, otherwise hold.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            held_q  <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (in_valid_i && in_ready_o) begin
            valid_q <= 1'b1;
            held_q  <= in_hdr;
        end else if (fire_out) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage with a scoreboard queue drained by an output monitor.
// Latency: expectations are pushed at accept and popped on each out handshake.
// Backpressure: out_ready is toggled by the stimulus; monitor only compares on handshakes.
module tb_operand_stage;

    localparam logic [4:0] U1 = 5'b10000, U2 = 5'b01000, PC1 = 5'b00100, IMM2 = 5'b00010, JALR = 5'b00001;

    typedef struct {
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] rs2d;
        logic        jmp;
        logic [31:0] rpc;
        logic [4:0]  rd;
        logic [7:0]  ctrl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0, in_imm = '0;
    logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
    logic [5:0]  in_alu_op = '0;
    logic [4:0]  in_sel = '0;
    logic [1:0]  in_jmp_opt = '0;
    logic [7:0]  in_ctrl = '0;
    logic [4:0]  rf_rs1, rf_rs2;
    logic [31:0] rf_rs1_data, rf_rs2_data;
    logic [1:0]  fwd_valid = '0, fwd_pend = '0;
    logic [9:0]  fwd_rd = '0;
    logic [63:0] fwd_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_src1, out_src2, out_rs2_data, out_pc, redirect_pc;
    logic [4:0]  out_rd;
    logic [5:0]  out_alu_op;
    logic [7:0]  out_ctrl;
    logic        out_jmp, redirect;

    logic [31:0] rf_mem [32];
    exp_t        sb_q [$];
    int          checks = 0;
    int          errors = 0;

    assign rf_rs1_data = rf_mem[rf_rs1];
    assign rf_rs2_data = rf_mem[rf_rs2];

    always #5 clk = ~clk;

    operand_stage dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_pc_i(in_pc), .in_imm_i(in_imm), .in_rs1_i(in_rs1), .in_rs2_i(in_rs2), .in_rd_i(in_rd),
        .in_alu_op_i(in_alu_op), .in_sel_i(in_sel), .in_jmp_opt_i(in_jmp_opt), .in_ctrl_i(in_ctrl),
        .rf_rs1_o(rf_rs1), .rf_rs2_o(rf_rs2), .rf_rs1_data_i(rf_rs1_data), .rf_rs2_data_i(rf_rs2_data),
        .fwd_valid_i(fwd_valid), .fwd_pend_i(fwd_pend), .fwd_rd_i(fwd_rd), .fwd_data_i(fwd_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_src1_o(out_src1), .out_src2_o(out_src2), .out_rs2_data_o(out_rs2_data),
        .out_rd_o(out_rd), .out_alu_op_o(out_alu_op), .out_ctrl_o(out_ctrl), .out_pc_o(out_pc),
        .out_jmp_o(out_jmp), .redirect_o(redirect), .redirect_pc_o(redirect_pc)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] s1, s2, r2, input logic j, input logic [31:0] rpc,
                                input logic [4:0] rd, input logic [7:0] ctrl);
        exp_t e;
        e.src1 = s1; e.src2 = s2; e.rs2d = r2; e.jmp = j; e.rpc = rpc; e.rd = rd; e.ctrl = ctrl;
        return e;
    endfunction

    // Monitor: every output handshake must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_fire", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("src1", out_src1, e.src1);
                check("src2", out_src2, e.src2);
                check("rs2_data", out_rs2_data, e.rs2d);
                check("jmp", {31'd0, out_jmp}, {31'd0, e.jmp});
                check("redirect", {31'd0, redirect}, {31'd0, e.jmp});
                check("redirect_pc", redirect_pc, e.rpc);
                check("rd", {27'd0, out_rd}, {27'd0, e.rd});
                check("ctrl", {24'd0, out_ctrl}, {24'd0, e.ctrl});
            end
        end
    end

    // Present one instruction until accepted; queue its expectation when push is set.
    task automatic issue(input logic [31:0] pc, imm, input logic [4:0] rs1, rs2, input logic [5:0] op,
                         input logic [4:0] sel, input logic [1:0] jo, input exp_t e, input bit push);
        bit rdy = 1'b0;
        in_valid = 1'b1; in_pc = pc; in_imm = imm; in_rs1 = rs1; in_rs2 = rs2; in_rd = e.rd;
        in_alu_op = op; in_sel = sel; in_jmp_opt = jo; in_ctrl = e.ctrl;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
        end
        in_valid = 1'b0;
        if (!rdy) check("accept_timeout", 32'd0, 32'd1);
        else if (push) sb_q.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 50; i++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("drain_left", sb_q.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'hDEAD_0000 | i;
        // Reset state
        #3;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_redirect", {31'd0, redirect}, 32'd0);
        check("rst_src1", out_src1, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Forwarding priority: channel 0 beats channel 1 and the register file
        rf_mem[5] = 32'h1;
        fwd_valid = 2'b11; fwd_rd = {5'd5, 5'd5}; fwd_data = {32'hBBBB, 32'hAAAA};
        issue(32'h40, 32'h4, 5'd5, 5'd0, 6'd0, U1 | IMM2, 2'b00, mk(32'hAAAA, 32'h4, 32'h0, 1'b0, 32'h44, 5'd7, 8'hC1), 1'b1);
        drain();

        // x0 ignores forwarding and pending matches
        rf_mem[0] = 32'h7;
        fwd_valid = 2'b01; fwd_pend = 2'b01; fwd_rd = 10'd0; fwd_data = {32'h0, 32'hFFFF};
        issue(32'h80, 32'h8, 5'd0, 5'd0, 6'd0, U1 | U2, 2'b00, mk(32'h0, 32'h0, 32'h0, 1'b0, 32'h88, 5'd1, 8'h11), 1'b1);
        drain();
        rf_mem[0] = 32'h0;

        // Load-use stall for two cycles, then forwarded data on channel 1
        rf_mem[3] = 32'h99;
        fwd_valid = 2'b00; fwd_pend = 2'b10; fwd_rd = {5'd3, 5'd0}; fwd_data = '0;
        issue(32'hC0, 32'h10, 5'd0, 5'd3, 6'd0, U2, 2'b00, mk(32'h0, 32'h3333, 32'h3333, 1'b0, 32'hD0, 5'd2, 8'h22), 1'b1);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("stall_out_valid", {31'd0, out_valid}, 32'd0);
            check("stall_in_ready", {31'd0, in_ready}, 32'd1 - 32'd1);
            @(posedge clk); #1;
        end
        fwd_pend = 2'b00; fwd_valid = 2'b10; fwd_data = {32'h3333, 32'h0};
        drain();
        fwd_valid = 2'b00; fwd_rd = '0; fwd_data = '0;

        // beq taken under three cycles of backpressure, then a single redirect pulse
        rf_mem[1] = 32'd9; rf_mem[2] = 32'd9;
        out_ready = 1'b0;
        issue(32'h100, 32'h20, 5'd1, 5'd2, 6'd0, U1 | U2, 2'b10, mk(32'd9, 32'd9, 32'd9, 1'b1, 32'h120, 5'd0, 8'h33), 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_redirect", {31'd0, redirect}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        drain();
        @(negedge clk);
        check("redirect_once", {31'd0, redirect}, 32'd0);
        @(posedge clk); #1;

        // bne not taken, blt signed taken, bltu not taken, unused compare code
        issue(32'h200, 32'h40, 5'd1, 5'd2, 6'd1, U1 | U2, 2'b10, mk(32'd9, 32'd9, 32'd9, 1'b0, 32'h240, 5'd0, 8'h34), 1'b1);
        drain();
        rf_mem[1] = 32'hFFFF_FFFF; rf_mem[2] = 32'd1;
        issue(32'h300, 32'h10, 5'd1, 5'd2, 6'd4, U1 | U2, 2'b10, mk(32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1, 32'h310, 5'd0, 8'h35), 1'b1);
        issue(32'h400, 32'h10, 5'd1, 5'd2, 6'd6, U1 | U2, 2'b10, mk(32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 32'h410, 5'd0, 8'h36), 1'b1);
        issue(32'h480, 32'h0, 5'd1, 5'd2, 6'd2, U1 | U2, 2'b10, mk(32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 32'h480, 5'd0, 8'h37), 1'b1);
        drain();

        // jalr clears bit 0; jal target wraps modulo 2^32
        rf_mem[6] = 32'h2001;
        issue(32'h500, 32'h4, 5'd6, 5'd0, 6'd0, U1 | PC1 | JALR, 2'b01, mk(32'h500, 32'h0, 32'h0, 1'b1, 32'h2004, 5'd1, 8'h44), 1'b1);
        issue(32'hFFFF_FFF0, 32'h20, 5'd0, 5'd0, 6'd0, PC1 | IMM2, 2'b01, mk(32'hFFFF_FFF0, 32'h20, 32'h0, 1'b1, 32'h10, 5'd1, 8'h45), 1'b1);
        drain();

        // Flush during a stall while a taken jump is offered upstream
        fwd_pend = 2'b10; fwd_rd = {5'd3, 5'd0};
        issue(32'h600, 32'h8, 5'd0, 5'd3, 6'd0, U2, 2'b00, mk(32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 5'd3, 8'h55), 1'b0);
        in_valid = 1'b1; in_pc = 32'h700; in_imm = 32'h40; in_rs1 = 5'd0; in_rs2 = 5'd0;
        in_sel = PC1 | IMM2; in_jmp_opt = 2'b01;
        flush = 1'b1;
        @(negedge clk);
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_redirect", {31'd0, redirect}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; fwd_pend = 2'b00;
        @(negedge clk);
        check("post_flush_valid", {31'd0, out_valid}, 32'd0);
        check("post_flush_redirect", {31'd0, redirect}, 32'd0);
        check("post_flush_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a stall
        fwd_pend = 2'b10;
        issue(32'h800, 32'h8, 5'd0, 5'd3, 6'd0, U2, 2'b00, mk(32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 5'd4, 8'h66), 1'b0);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_rf_rs2", {27'd0, rf_rs2}, 32'd0);
        check("arst_out_pc", out_pc, 32'd0);
        check("arst_redirect_pc", redirect_pc, 32'd0);
        check("arst_ctrl", {24'd0, out_ctrl}, 32'd0);
        @(posedge clk); #1;
        fwd_pend = 2'b00;
        rst_n = 1'b1;
        @(negedge clk);
        check("after_rst_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;

        check("queue_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
